msg_out_fifo: RTL

Message buffer between the message parser's output (`msg_valid`/`msg_length`/`msg_data`/`msg_error`) and the downstream consumer. The parser has no backpressure input, so this block absorbs its one-cycle message pulses. It stores whole messages in a small register-based FIFO and presents them on a valid/ready output port. Errored, zero-length and overflowing messages are dropped, and each kind of drop is counted.

---
 rtl/msg_out_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/msg_out_fifo.sv
// Buffers whole parser messages in a small FIFO and presents them on a valid/ready port.
// Messages that are errored, zero-length or overflowing are dropped, and each drop kind is counted.
module msg_out_fifo #(
    parameter int MAX_MSG_BYTES = 32,
    parameter int DEPTH         = 4,
    parameter int DROP_ERRORED  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       msg_valid,
    input  logic [15:0]                msg_length,
    input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
    input  logic                       msg_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_length,
    output logic [8*MAX_MSG_BYTES-1:0] out_data,
    output logic                       out_error,
    output logic [$clog2(DEPTH):0]     fill_count,
    output logic [15:0]                drop_full_count,
    output logic [15:0]                drop_err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = 8 * MAX_MSG_BYTES;

    logic [DW-1:0] mem_data_q [DEPTH];
    logic [15:0]   mem_len_q  [DEPTH];
    logic          mem_err_q  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [15:0]   drop_full_q, drop_full_d;
    logic [15:0]   drop_err_q, drop_err_d;

    logic full;
    logic pop;
    logic bad_msg;
    logic wr_en;
    logic drop_full;

    // A pop in the same cycle frees a slot, so a full FIFO can still take the write.
    always_comb begin
        full      = (fill_q == CW'(DEPTH));
        pop       = (fill_q != '0) && out_ready;
        bad_msg   = msg_valid && ((msg_length == 16'd0) || ((DROP_ERRORED != 0) && msg_error));
        wr_en     = msg_valid && !bad_msg && (!full || pop);
        drop_full = msg_valid && !bad_msg && full && !pop;
    end

    always_comb begin
        wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fill_d      = fill_q;
        if (wr_en && !pop) begin
            fill_d = fill_q + CW'(1);
        end else if (!wr_en && pop) begin
            fill_d = fill_q - CW'(1);
        end
        drop_full_d = drop_full_q;
        if (drop_full && (drop_full_q != 16'hFFFF)) begin
            drop_full_d = drop_full_q + 16'd1;
        end
        drop_err_d  = drop_err_q;
        if (bad_msg && (drop_err_q != 16'hFFFF)) begin
            drop_err_d = drop_err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            drop_full_q <= '0;
            drop_err_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            drop_full_q <= drop_full_d;
            drop_err_q  <= drop_err_d;
        end
    end

    // Slot contents need no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data_q[wr_ptr_q] <= msg_data;
            mem_len_q[wr_ptr_q]  <= msg_length;
            mem_err_q[wr_ptr_q]  <= msg_error;
        end
    end

    always_comb begin
        out_valid       = (fill_q != '0);
        out_length      = out_valid ? mem_len_q[rd_ptr_q]  : 16'd0;
        out_data        = out_valid ? mem_data_q[rd_ptr_q] : '0;
        out_error       = out_valid ? mem_err_q[rd_ptr_q]  : 1'b0;
        fill_count      = fill_q;
        drop_full_count = drop_full_q;
        drop_err_count  = drop_err_q;
    end

endmodule
